// File: rtl/signed_sat_accum_stream.sv
// signed_sat_accum_stream: saturating signed block accumulator with valid/ready handshake
module signed_sat_accum_stream #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_overflow
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [W-1:0] acc, raw, sat;
  logic [CW-1:0] cnt;
  logic sticky, ovf, accept, last;
  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == HOLD;
    accept    = in_valid && in_ready;
    last      = cnt == CW'(N - 1);
    raw       = acc + in_data;
    ovf       = (acc[W-1] == in_data[W-1]) && (raw[W-1] != acc[W-1]);
    sat       = ovf ? (acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
    state_nxt = state;
    if (accept && last) state_nxt = HOLD;
    if (out_valid && out_ready) state_nxt = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc    <= sat;
        sticky <= sticky | ovf;
        cnt    <= last ? '0 : cnt + CW'(1);
        if (last) begin
          out_sum      <= sat;
          out_overflow <= sticky | ovf;
        end
      end
      if (out_valid && out_ready) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_signed_sat_accum_stream.sv
// tb_signed_sat_accum_stream: directed and randomized checks against an integer clamp model
module tb_signed_sat_accum_stream;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [3:0] in_data = '0;
  logic in_ready, out_valid, out_overflow;
  logic [3:0] out_sum;
  int vectors = 0, errors = 0;

  signed_sat_accum_stream #(.W(4), .N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Exact integer sum clamped to [-8,7] after each addition.
  function automatic void ref_block(input int s[4], output int sum, output bit o);
    sum = 0;
    o = 0;
    foreach (s[i]) begin
      sum += s[i];
      if (sum > 7) begin sum = 7; o = 1; end
      else if (sum < -8) begin sum = -8; o = 1; end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input string tag);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before sample: got %b want 1", tag, in_ready);
    end
    in_valid = 1;
    in_data = 4'(x);
    step();
    in_valid = 0;
    in_data = 4'($urandom);
  endtask

  // Feeds one block, optionally with idle gaps and backpressure, then checks the result.
  task automatic do_block(input int s[4], input int es, input bit eo, input int max_gap,
                          input int hold, input string tag);
    for (int i = 0; i < 4; i++) begin
      int g = max_gap < 0 ? (i > 0 ? 1 : 0) : int'($urandom_range(0, max_gap));
      repeat (g) begin
        in_valid = 0;
        in_data = 4'($urandom);
        step();
      end
      push(s[i], tag);
    end
    for (int h = 0; h <= hold; h++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 4'(es) || out_overflow !== eo || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s result cycle %0d: valid=%b sum=%0d ovf=%b rdy=%b want valid=1 sum=%0d ovf=%b rdy=0",
                 tag, h, out_valid, $signed(out_sum), out_overflow, in_ready, es, eo);
      end
      if (h < hold) begin
        in_valid = 1;
        in_data = 4'd5;
        out_ready = 0;
        step();
        in_valid = 0;
      end
    end
    out_ready = 1;
    step();
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after handshake: valid=%b rdy=%b want valid=0 rdy=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    vectors++;
    if (out_valid !== 0 || out_sum !== 0 || out_overflow !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset: valid=%b sum=%0d ovf=%b rdy=%b want 0 0 0 1", out_valid, out_sum, out_overflow, in_ready);
    end
  endtask

  task automatic test_basic();
    do_block('{1, 2, -1, 3}, 5, 0, 0, 0, "basic");
  endtask

  task automatic test_saturation();
    do_block('{4, 7, -2, 1}, 6, 1, 0, 0, "pos_sat");
    do_block('{-4, -7, -1, 0}, -8, 1, 0, 0, "neg_sat");
    do_block('{-8, -8, 1, 0}, -7, 1, 0, 0, "neg_min");
    do_block('{-8, 0, 0, 0}, -8, 0, 0, 0, "min_plus_zero");
  endtask

  task automatic test_backpressure();
    do_block('{1, 1, 1, 1}, 4, 0, 0, 3, "backpressure");
    do_block('{2, 2, 2, -3}, 3, 0, 0, 0, "after_bp");
  endtask

  task automatic test_gaps();
    do_block('{3, 3, 1, -8}, -1, 0, -1, 0, "gaps");
  endtask

  task automatic test_reset_mid();
    push(6, "mid_rst");
    push(6, "mid_rst");
    rst = 1;
    step();
    rst = 0;
    vectors++;
    if (out_valid !== 0 || out_sum !== 0 || out_overflow !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL mid_rst outputs: valid=%b sum=%0d ovf=%b rdy=%b want 0 0 0 1", out_valid, out_sum, out_overflow, in_ready);
    end
    do_block('{1, 1, 1, 1}, 4, 0, 0, 0, "after_mid_rst");
    for (int i = 0; i < 4; i++) push(2, "hold_rst");
    vectors++;
    if (out_valid !== 1) begin
      errors++;
      $display("FAIL hold_rst valid before reset: got %b want 1", out_valid);
    end
    out_ready = 1;
    rst = 1;
    step();
    rst = 0;
    out_ready = 0;
    vectors++;
    if (out_valid !== 0 || out_sum !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL hold_rst: valid=%b sum=%0d rdy=%b want 0 0 1", out_valid, out_sum, in_ready);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 60; b++) begin
      int s[4];
      int es;
      bit eo;
      foreach (s[i]) s[i] = int'($urandom_range(0, 15)) - 8;
      ref_block(s, es, eo);
      do_block(s, es, eo, b % 3, int'($urandom_range(0, 2)), $sformatf("rand%0d", b));
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 10; b++) begin
      int s[4];
      int es;
      bit eo;
      foreach (s[i]) s[i] = (b % 2) ? 7 - i : -8 + i;
      ref_block(s, es, eo);
      do_block(s, es, eo, 0, 0, $sformatf("b2b%0d", b));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
